uart_frame_controller: RTL and testbench

UART_FRAME_CONTROLLER -- requirements
Module: uart_frame_controller

---
 rtl/uart_frame_controller.sv | 158 +++++++++++++++
 tb/tb_uart_frame_controller.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_controller.sv
// Frame controller between a UART receiver/transmitter pair and a streaming datapath:
// buffers one host frame, feeds it to the datapath, and serialises the results back out.
module uart_frame_controller #(
    parameter int         BUFFER_DEPTH = 64,
    parameter logic [7:0] TERMINATOR   = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        dp_in_valid,
    output logic [7:0]  dp_in_data,
    output logic        dp_in_last,
    input  logic        dp_in_ready,
    input  logic        dp_out_valid,
    input  logic [7:0]  dp_out_data,
    input  logic        dp_out_last,
    output logic        dp_out_ready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        busy,
    output logic        overflow,
    output logic        dropped,
    output logic [15:0] frame_count
);

    localparam int IDX_W = $clog2(BUFFER_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] FULL = PTR_W'(BUFFER_DEPTH);

    typedef enum logic [2:0] {IDLE, RECEIVE, DISCARD, FEED, DRAIN} state_t;

    state_t           state;
    logic [7:0]       buffer [BUFFER_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             done;
    logic             in_fire;
    logic             out_fire;
    logic             is_term;
    logic             full;
    logic             accepting;
    logic             result_phase;
    logic             drain_exit;

    assign in_fire      = dp_in_valid & dp_in_ready;
    assign out_fire     = dp_out_valid & dp_out_ready;
    assign is_term      = (rx_data == TERMINATOR);
    assign full         = (wr_ptr == FULL);
    assign accepting    = (state == IDLE) || (state == RECEIVE);
    assign result_phase = (state == FEED) || (state == DRAIN);
    assign rd_next      = rd_ptr + PTR_W'(1);
    // A result accepted this cycle still has to be launched, so it blocks the exit.
    assign drain_exit   = (state == DRAIN) && done && !tx_start && !tx_busy && !out_fire;
    assign busy         = (state != IDLE);

    // Frame storage: data only, validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (!reset && accepting && rx_valid && !full) begin
            buffer[wr_ptr[IDX_W-1:0]] <= rx_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            dp_in_valid  <= 1'b0;
            dp_in_data   <= 8'h00;
            dp_in_last   <= 1'b0;
            dp_out_ready <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= 8'h00;
            overflow     <= 1'b0;
            dropped      <= 1'b0;
            frame_count  <= 16'h0000;
            done         <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            if (out_fire) begin
                tx_data      <= dp_out_data;
                tx_start     <= 1'b1;
                dp_out_ready <= 1'b0;
                if (dp_out_last) begin
                    done <= 1'b1;
                end
            end else begin
                dp_out_ready <= result_phase && !tx_busy && !tx_start && !drain_exit;
            end

            if (rx_valid && result_phase) begin
                dropped <= 1'b1;
            end

            case (state)
                IDLE, RECEIVE: begin
                    if (rx_valid) begin
                        if (full) begin
                            overflow <= 1'b1;
                            if (is_term) begin
                                state  <= IDLE;
                                wr_ptr <= '0;
                                rd_ptr <= '0;
                            end else begin
                                state <= DISCARD;
                            end
                        end else begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            if (is_term) begin
                                // The first beat may be the byte being written right now.
                                state       <= FEED;
                                dp_in_valid <= 1'b1;
                                dp_in_data  <= (wr_ptr == '0) ? rx_data : buffer[0];
                                dp_in_last  <= (wr_ptr == '0);
                            end else begin
                                state <= RECEIVE;
                            end
                        end
                    end
                end
                DISCARD: begin
                    if (rx_valid && is_term) begin
                        state  <= IDLE;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                end
                FEED: begin
                    if (in_fire) begin
                        if (dp_in_last) begin
                            dp_in_valid <= 1'b0;
                            dp_in_last  <= 1'b0;
                            state       <= DRAIN;
                        end else begin
                            rd_ptr     <= rd_next;
                            dp_in_data <= buffer[rd_next[IDX_W-1:0]];
                            dp_in_last <= ((rd_ptr + PTR_W'(2)) == wr_ptr);
                        end
                    end
                end
                DRAIN: begin
                    if (drain_exit) begin
                        state       <= IDLE;
                        wr_ptr      <= '0;
                        rd_ptr      <= '0;
                        done        <= 1'b0;
                        frame_count <= frame_count + 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_controller.sv
// Directed bench for uart_frame_controller: buffered datapath model, transmitter model,
// and a second small-buffer instance for the overflow path.
module tb_uart_frame_controller;

    localparam int TX_LEN = 8;
    typedef logic [7:0] bq_t [$];

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        dp_in_valid, dp_in_last, dp_in_ready;
    logic [7:0]  dp_in_data;
    logic        dp_out_valid, dp_out_last, dp_out_ready;
    logic [7:0]  dp_out_data;
    logic        tx_start, tx_busy, busy, overflow, dropped;
    logic [7:0]  tx_data;
    logic [15:0] frame_count;

    logic        s_rx_valid = 1'b0;
    logic [7:0]  s_rx_data = 8'h00;
    logic        s_dp_in_valid, s_dp_in_last, s_dp_out_ready;
    logic [7:0]  s_dp_in_data;
    logic        s_tx_start, s_busy, s_overflow, s_dropped;
    logic [7:0]  s_tx_data;
    logic [15:0] s_frame_count;

    int n_asserts = 0;
    int n_fail = 0;

    uart_frame_controller dut (
        .clock(clock), .reset(reset), .rx_valid(rx_valid), .rx_data(rx_data),
        .dp_in_valid(dp_in_valid), .dp_in_data(dp_in_data), .dp_in_last(dp_in_last),
        .dp_in_ready(dp_in_ready), .dp_out_valid(dp_out_valid), .dp_out_data(dp_out_data),
        .dp_out_last(dp_out_last), .dp_out_ready(dp_out_ready), .tx_start(tx_start),
        .tx_data(tx_data), .tx_busy(tx_busy), .busy(busy), .overflow(overflow),
        .dropped(dropped), .frame_count(frame_count)
    );

    uart_frame_controller #(.BUFFER_DEPTH(4), .TERMINATOR(8'h00)) dut_small (
        .clock(clock), .reset(reset), .rx_valid(s_rx_valid), .rx_data(s_rx_data),
        .dp_in_valid(s_dp_in_valid), .dp_in_data(s_dp_in_data), .dp_in_last(s_dp_in_last),
        .dp_in_ready(s_dp_out_ready), .dp_out_valid(s_dp_in_valid), .dp_out_data(s_dp_in_data),
        .dp_out_last(s_dp_in_last), .dp_out_ready(s_dp_out_ready), .tx_start(s_tx_start),
        .tx_data(s_tx_data), .tx_busy(1'b0), .busy(s_busy), .overflow(s_overflow),
        .dropped(s_dropped), .frame_count(s_frame_count)
    );

    // One-entry loopback datapath, optionally throttled on alternate cycles.
    logic       hold_v = 1'b0;
    logic [7:0] hold_d = 8'h00;
    logic       hold_l = 1'b0;
    logic       stall_mode = 1'b0;
    logic       phase = 1'b0;

    assign dp_in_ready  = !hold_v && (!stall_mode || phase);
    assign dp_out_valid = hold_v;
    assign dp_out_data  = hold_d;
    assign dp_out_last  = hold_l;

    always @(posedge clock) begin
        phase <= ~phase;
        if (reset) begin
            hold_v <= 1'b0;
        end else begin
            if (dp_out_valid && dp_out_ready) hold_v <= 1'b0;
            if (dp_in_valid && dp_in_ready) begin
                hold_v <= 1'b1;
                hold_d <= dp_in_data;
                hold_l <= dp_in_last;
            end
        end
    end

    // Transmitter model and stream monitors.
    logic [8:0] in_q [$];
    logic [7:0] tx_q [$];
    int         tx_cnt = 0;
    int         stall_cnt = 0;
    int         stab_err = 0;
    logic       stalled = 1'b0;
    logic [7:0] sv_d = 8'h00;
    logic       sv_l = 1'b0;
    int         s_in_valid_cnt = 0;
    int         s_tx_cnt = 0;

    assign tx_busy = (tx_cnt != 0);

    always @(posedge clock) begin
        if (dp_in_valid && dp_in_ready) in_q.push_back({dp_in_last, dp_in_data});
        if (stalled && !(dp_in_valid && dp_in_data == sv_d && dp_in_last == sv_l))
            stab_err <= stab_err + 1;
        stalled <= dp_in_valid && !dp_in_ready && !reset;
        if (dp_in_valid && !dp_in_ready) begin
            stall_cnt <= stall_cnt + 1;
            sv_d      <= dp_in_data;
            sv_l      <= dp_in_last;
        end
        if (tx_start) begin
            tx_q.push_back(tx_data);
            tx_cnt <= TX_LEN;
        end else if (tx_cnt != 0) begin
            tx_cnt <= tx_cnt - 1;
        end
        if (s_dp_in_valid) s_in_valid_cnt <= s_in_valid_cnt + 1;
        if (s_tx_start) s_tx_cnt <= s_tx_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input bit sel, input logic [7:0] b);
        if (sel) begin
            s_rx_valid = 1'b1;
            s_rx_data  = b;
        end else begin
            rx_valid = 1'b1;
            rx_data  = b;
        end
        @(negedge clock);
        rx_valid   = 1'b0;
        s_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input bit sel, input bq_t f);
        foreach (f[i]) begin
            send(sel, f[i]);
            if (i != f.size() - 1) @(negedge clock);
        end
    endtask

    task automatic wait_idle(input bit sel, input string tag);
        for (int i = 0; i < 600 && ((sel ? s_busy : busy) == 1'b1); i++) @(negedge clock);
        chk(tag, sel ? s_busy : busy, 0);
    endtask

    task automatic wait_in_beats(input int n);
        for (int i = 0; i < 300 && in_q.size() < n; i++) @(negedge clock);
    endtask

    task automatic check_stream(input string tag, input int base_in, input int base_tx, input bq_t exp);
        chk($sformatf("%s_in_count", tag), in_q.size() - base_in, exp.size());
        chk($sformatf("%s_tx_count", tag), tx_q.size() - base_tx, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (base_in + i < in_q.size())
                chk($sformatf("%s_in%0d", tag, i), in_q[base_in + i], {(i == exp.size() - 1), exp[i]});
            if (base_tx + i < tx_q.size())
                chk($sformatf("%s_tx%0d", tag, i), tx_q[base_tx + i], exp[i]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_dp_in_valid"}, dp_in_valid, 0);
        chk({tag, "_dp_in_data"}, dp_in_data, 0);
        chk({tag, "_dp_in_last"}, dp_in_last, 0);
        chk({tag, "_dp_out_ready"}, dp_out_ready, 0);
        chk({tag, "_tx_start"}, tx_start, 0);
        chk({tag, "_tx_data"}, tx_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_overflow"}, overflow, 0);
        chk({tag, "_dropped"}, dropped, 0);
        chk({tag, "_frame_count"}, frame_count, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bi, bt, s0, sv0, st0;

        repeat (3) @(negedge clock);
        check_reset_outputs("rst");
        chk("rst_small_busy", s_busy, 0);
        chk("rst_small_overflow", s_overflow, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Loopback frame 48 65 00 with one-cycle terminator latency.
        bi = in_q.size(); bt = tx_q.size();
        send(0, 8'h48); @(negedge clock);
        send(0, 8'h65); @(negedge clock);
        chk("pre_term_valid", dp_in_valid, 0);
        send(0, 8'h00);
        chk("lat_valid", dp_in_valid, 1);
        chk("lat_data", dp_in_data, 8'h48);
        chk("lat_last", dp_in_last, 0);
        chk("feed_busy", busy, 1);
        wait_idle(0, "f1_idle");
        check_stream("f1", bi, bt, '{8'h48, 8'h65, 8'h00});
        chk("f1_count", frame_count, 1);

        // Empty frame: terminator only.
        bi = in_q.size(); bt = tx_q.size();
        send(0, 8'h00);
        chk("empty_valid", dp_in_valid, 1);
        chk("empty_data", dp_in_data, 8'h00);
        chk("empty_last", dp_in_last, 1);
        wait_idle(0, "f2_idle");
        check_stream("f2", bi, bt, '{8'h00});
        chk("f2_count", frame_count, 2);

        // Throttled datapath input.
        bi = in_q.size(); bt = tx_q.size(); s0 = stall_cnt;
        stall_mode = 1'b1;
        send_frame(0, '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00});
        wait_idle(0, "f3_idle");
        stall_mode = 1'b0;
        check_stream("f3", bi, bt, '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h00});
        chk("f3_stalls_seen", stall_cnt > s0, 1);
        chk("f3_stable", stab_err, 0);
        chk("f3_count", frame_count, 3);

        // Byte arriving while draining results is dropped.
        bi = in_q.size(); bt = tx_q.size();
        send_frame(0, '{8'h41, 8'h42, 8'h00});
        wait_in_beats(bi + 3);
        @(negedge clock);
        chk("f4_draining", busy, 1);
        chk("f4_dropped_before", dropped, 0);
        send(0, 8'h55);
        chk("f4_dropped", dropped, 1);
        wait_idle(0, "f4_idle");
        check_stream("f4", bi, bt, '{8'h41, 8'h42, 8'h00});
        chk("f4_count", frame_count, 4);
        chk("f4_dropped_sticky", dropped, 1);

        // Reset while draining with the transmitter busy.
        bi = in_q.size();
        send_frame(0, '{8'h41, 8'h00});
        wait_in_beats(bi + 2);
        for (int i = 0; i < 50 && !tx_busy; i++) @(negedge clock);
        chk("f5_busy_pre", busy, 1);
        chk("f5_txbusy_pre", tx_busy, 1);
        reset = 1'b1;
        @(negedge clock);
        check_reset_outputs("midrst");
        reset = 1'b0;
        bt = tx_q.size();
        repeat (20) @(negedge clock);
        chk("no_tx_after_reset", tx_q.size() - bt, 0);
        bi = in_q.size(); bt = tx_q.size();
        send_frame(0, '{8'h41, 8'h00});
        wait_idle(0, "f6_idle");
        check_stream("f6", bi, bt, '{8'h41, 8'h00});
        chk("f6_count", frame_count, 1);

        // Small buffer: oversized frame discarded, then normal and exactly-full frames.
        sv0 = s_in_valid_cnt; st0 = s_tx_cnt;
        send_frame(1, '{8'h41, 8'h42, 8'h43, 8'h44, 8'h45, 8'h00});
        repeat (3) @(negedge clock);
        chk("ovf_no_valid", s_in_valid_cnt - sv0, 0);
        chk("ovf_flag", s_overflow, 1);
        chk("ovf_idle", s_busy, 0);
        chk("ovf_count", s_frame_count, 0);
        chk("ovf_no_tx", s_tx_cnt - st0, 0);
        send_frame(1, '{8'h41, 8'h00});
        chk("s1_valid", s_dp_in_valid, 1);
        chk("s1_data", s_dp_in_data, 8'h41);
        wait_idle(1, "s1_idle");
        chk("s1_count", s_frame_count, 1);
        chk("s1_tx", s_tx_cnt - st0, 2);
        send_frame(1, '{8'h41, 8'h42, 8'h43, 8'h00});
        wait_idle(1, "s2_idle");
        chk("s2_count", s_frame_count, 2);
        chk("s2_tx", s_tx_cnt - st0, 6);
        chk("s2_overflow_sticky", s_overflow, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
